// File: rtl/prbs32_checker.sv
// Self-synchronising checker for a 32-bit PRBS stream (taps 31,30,11,0).
// Hunts for alignment, confirms it, then free-runs and counts bit errors.
module prbs32_checker #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned WIN_LEN    = 64,
    parameter int unsigned ERR_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din_valid,
    input  logic        din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [31:0] bit_cnt
);

    localparam int unsigned FILL_W = 5;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);
    localparam int unsigned WERR_W = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [31:0]         c, c_n;
    logic [FILL_W-1:0]   fill_cnt, fill_cnt_n;
    logic [GOOD_W-1:0]   good_cnt, good_cnt_n;
    logic [WIN_W-1:0]    win_cnt, win_cnt_n;
    logic [WERR_W-1:0]   win_err, win_err_n;
    logic                locked_n;
    logic                err_pulse_n;
    logic [15:0]         err_cnt_n;
    logic [31:0]         bit_cnt_n;
    logic                pred;
    logic                bit_err;

    assign pred = c[31] ^ c[30] ^ c[11] ^ c[0];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            c         <= '0;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_n;
            c         <= c_n;
            fill_cnt  <= fill_cnt_n;
            good_cnt  <= good_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            locked    <= locked_n;
            err_pulse <= err_pulse_n;
            err_cnt   <= err_cnt_n;
            bit_cnt   <= bit_cnt_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        c_n        = c;
        fill_cnt_n = fill_cnt;
        good_cnt_n = good_cnt;
        win_cnt_n  = win_cnt;
        win_err_n  = win_err;
        err_cnt_n  = err_cnt;
        bit_cnt_n  = bit_cnt;
        bit_err    = 1'b0;

        if (!en) begin
            state_n    = HUNT;
            fill_cnt_n = '0;
            good_cnt_n = '0;
            win_cnt_n  = '0;
            win_err_n  = '0;
        end else if (din_valid) begin
            case (state)
                HUNT: begin
                    c_n = {din, c[31:1]};
                    if (fill_cnt == FILL_W'(31)) begin
                        fill_cnt_n = '0;
                        good_cnt_n = '0;
                        // An all-zero seed would predict zeros forever; keep hunting.
                        if (c_n != '0) begin
                            state_n = CONFIRM;
                        end
                    end else begin
                        fill_cnt_n = fill_cnt + FILL_W'(1);
                    end
                end
                CONFIRM: begin
                    c_n = {din, c[31:1]};
                    if (din == pred) begin
                        if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            state_n    = LOCKED;
                            good_cnt_n = '0;
                            win_cnt_n  = '0;
                            win_err_n  = '0;
                        end else begin
                            good_cnt_n = good_cnt + GOOD_W'(1);
                        end
                    end else begin
                        state_n    = HUNT;
                        fill_cnt_n = '0;
                        good_cnt_n = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so one channel error counts once.
                    c_n     = {pred, c[31:1]};
                    bit_err = (din != pred);
                    if (bit_cnt != '1) begin
                        bit_cnt_n = bit_cnt + 32'd1;
                    end
                    if (bit_err && (err_cnt != '1)) begin
                        err_cnt_n = err_cnt + 16'd1;
                    end
                    if (bit_err && (win_err == WERR_W'(ERR_THRESH - 1))) begin
                        state_n    = HUNT;
                        fill_cnt_n = '0;
                        win_cnt_n  = '0;
                        win_err_n  = '0;
                    end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WIN_W'(1);
                        if (bit_err) begin
                            win_err_n = win_err + WERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_n    = HUNT;
                    fill_cnt_n = '0;
                    good_cnt_n = '0;
                    win_cnt_n  = '0;
                    win_err_n  = '0;
                end
            endcase
        end

        if (clr_cnt) begin
            err_cnt_n = '0;
            bit_cnt_n = '0;
        end

        locked_n    = (state_n == LOCKED);
        err_pulse_n = bit_err;
    end

endmodule

// File: tb/tb_prbs32_checker.sv
// Directed bench for prbs32_checker driven by a 32-bit PRBS generator model.
module tb_prbs32_checker;

    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        din_valid;
    logic        din;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    logic        lock_seen = 1'b0;
    logic [31:0] g;

    prbs32_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic next_bit(output logic b);
        b = g[31] ^ g[30] ^ g[11] ^ g[0];
        g = {b, g[31:1]};
    endtask

    task automatic send(input logic b, input logic clr);
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        if (err_pulse) pulses++;
        if (locked) lock_seen = 1'b1;
    endtask

    task automatic send_gen(input logic flip, input logic clr);
        logic b;
        next_bit(b);
        send(b ^ flip, clr);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send_gen(1'b0, 1'b0);
    endtask

    task automatic idle();
        @(negedge clk);
        din       = 1'($urandom);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        g         = SEED;
        pulses    = 0;
        lock_seen = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (bit_cnt !== 32'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        send_clean(47);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_47 got=%b exp=0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_48 got=%b exp=1", locked); end
        checks++; if (bit_cnt !== 32'd0) begin errors++; $display("FAIL lock_bit_cnt0 got=%0d exp=0", bit_cnt); end
        send_clean(1000);
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (bit_cnt !== 32'd1000) begin errors++; $display("FAIL clean_bit_cnt got=%0d exp=1000", bit_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_locked got=%b exp=1", locked); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL clean_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_single_err();
        do_reset();
        send_clean(48);
        send_clean(99);
        send_gen(1'b1, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%b exp=1", err_pulse); end
        send_clean(1);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_len got=%b exp=0", err_pulse); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%b exp=1", locked); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        checks++; if (bit_cnt !== 32'd101) begin errors++; $display("FAIL single_bit_cnt got=%0d exp=101", bit_cnt); end
    endtask

    task automatic test_loss_relock();
        do_reset();
        send_clean(48);
        send_clean(10);
        for (int i = 0; i < 7; i++) send_gen(1'b1, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_7err_locked got=%b exp=1", locked); end
        send_gen(1'b1, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_8err_locked got=%b exp=0", locked); end
        checks++; if (err_cnt !== 16'd8) begin errors++; $display("FAIL loss_err_cnt got=%0d exp=8", err_cnt); end
        send_clean(47);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_47 got=%b exp=0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_48 got=%b exp=1", locked); end
        checks++; if (err_cnt !== 16'd8) begin errors++; $display("FAIL relock_err_cnt got=%0d exp=8", err_cnt); end
        checks++; if (pulses !== 8) begin errors++; $display("FAIL relock_pulses got=%0d exp=8", pulses); end
    endtask

    task automatic test_zero_stream();
        do_reset();
        for (int i = 0; i < 500; i++) send(1'b0, 1'b0);
        checks++; if (lock_seen !== 1'b0) begin errors++; $display("FAIL zero_lock_seen got=%b exp=0", lock_seen); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL zero_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL zero_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_window_retain();
        int pos;
        do_reset();
        send_clean(48);
        // Errors straddle each window boundary: 7 per aligned window.
        for (int k = 0; k < 640; k++) begin
            pos = k % 64;
            send_gen((pos <= 2) || (pos >= 60), 1'b0);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL win_locked got=%b exp=1", locked); end
        checks++; if (err_cnt !== 16'd70) begin errors++; $display("FAIL win_err_cnt got=%0d exp=70", err_cnt); end
        checks++; if (bit_cnt !== 32'd640) begin errors++; $display("FAIL win_bit_cnt got=%0d exp=640", bit_cnt); end
    endtask

    task automatic test_thresh_last_bit();
        do_reset();
        send_clean(48);
        send_clean(56);
        for (int i = 0; i < 7; i++) send_gen(1'b1, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL last_pre_locked got=%b exp=1", locked); end
        send_gen(1'b1, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL last_bit_locked got=%b exp=0", locked); end
        checks++; if (bit_cnt !== 32'd64) begin errors++; $display("FAIL last_bit_cnt got=%0d exp=64", bit_cnt); end
    endtask

    task automatic test_clr_cnt();
        do_reset();
        send_clean(48);
        send_clean(5);
        send_gen(1'b1, 1'b0);
        send_gen(1'b1, 1'b1);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got=%b exp=1", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (bit_cnt !== 32'd0) begin errors++; $display("FAIL clr_bit_cnt got=%0d exp=0", bit_cnt); end
        send_clean(1);
        checks++; if (bit_cnt !== 32'd1) begin errors++; $display("FAIL clr_bit_cnt_after got=%0d exp=1", bit_cnt); end
    endtask

    task automatic test_gaps();
        do_reset();
        send_clean(48);
        for (int i = 0; i < 30; i++) begin
            send_clean(1);
            idle();
            idle();
        end
        checks++; if (bit_cnt !== 32'd30) begin errors++; $display("FAIL gap_bit_cnt got=%0d exp=30", bit_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL gap_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked got=%b exp=1", locked); end
    endtask

    task automatic test_en_low();
        do_reset();
        send_clean(48);
        send_clean(5);
        @(negedge clk);
        en = 1'b0; din = 1'b1; din_valid = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b1; din_valid = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_locked got=%b exp=0", locked); end
        checks++; if (bit_cnt !== 32'd5) begin errors++; $display("FAIL en_bit_cnt got=%0d exp=5", bit_cnt); end
        send_clean(47);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_relock_47 got=%b exp=0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL en_relock_48 got=%b exp=1", locked); end
    endtask

    task automatic test_rst_locked();
        logic b;
        do_reset();
        send_clean(48);
        send_clean(5);
        send_gen(1'b1, 1'b0);
        send_clean(14);
        next_bit(b);
        @(negedge clk);
        rst = 1'b1; din = ~b; din_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; din_valid = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstl_locked got=%b exp=0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rstl_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rstl_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (bit_cnt !== 32'd0) begin errors++; $display("FAIL rstl_bit_cnt got=%0d exp=0", bit_cnt); end
        send_clean(47);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstl_relock_47 got=%b exp=0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstl_relock_48 got=%b exp=1", locked); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        g = SEED;
        repeat (2) @(posedge clk);
        test_reset();
        test_lock();
        test_single_err();
        test_loss_relock();
        test_zero_stream();
        test_window_retain();
        test_thresh_last_bit();
        test_clr_cnt();
        test_gaps();
        test_en_low();
        test_rst_locked();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs32_checker.md
PRBS32_CHECKER -- requirements
Module: prbs32_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive correct predictions required in CONFIRM before lock.
REQ-002 Parameter WIN_LEN, default 64: loss-of-lock observation window, in checked bits.
REQ-003 Parameter ERR_THRESH, default 8: errors within one window that force loss of lock.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  checker enable; when 0, din_valid is ignored.
REQ-007 din_valid  input  1  din carries a received bit this cycle.
REQ-008 din  input  1  received serial bit from a 32-bit PRBS source.
REQ-009 clr_cnt  input  1  synchronous clear of err_cnt and bit_cnt.
REQ-010 locked  output  1  registered lock indicator.
REQ-011 err_pulse  output  1  one-cycle pulse per mismatched bit while locked.
REQ-012 err_cnt  output  16  saturating error count.
REQ-013 bit_cnt  output  32  saturating count of bits checked while locked.

Function
REQ-014 The prediction register c[31:0] SHALL update on an accepted bit (en and din_valid) as {x, c[31:1]}; the prediction SHALL be p = c[31]^c[30]^c[11]^c[0].
REQ-015 The FSM SHALL have three states, HUNT, CONFIRM and LOCKED; the reset state SHALL be HUNT.
REQ-016 HUNT: x = din, and fill_cnt increments on each accepted bit; on the 32nd bit the FSM SHALL go to CONFIRM with good_cnt = 0, unless the next value of c is all-zero, in which case it SHALL stay in HUNT with fill_cnt = 0.
REQ-017 CONFIRM: x = din; on din == p, good_cnt increments; on the LOCK_CNT-th consecutive match the FSM SHALL go to LOCKED; on a mismatch it SHALL go to HUNT with fill_cnt = 0.
REQ-018 LOCKED: x = p, so the register free-runs and each channel error is counted exactly once; din != p SHALL be an error.
REQ-019 LOCKED: win_cnt counts accepted bits and win_err counts errors; when win_err reaches ERR_THRESH, the FSM SHALL go to HUNT with fill_cnt = 0.
REQ-020 When win_cnt reaches WIN_LEN-1 without loss of lock, win_cnt and win_err SHALL both restart at 0 on the next accepted bit.
REQ-021 If the threshold is reached on the final bit of a window, loss of lock SHALL take priority.
REQ-022 locked SHALL equal 1 in the cycle after the transition into LOCKED is registered, i.e. one cycle after the LOCK_CNT-th good bit is sampled.
REQ-023 locked SHALL fall one cycle after the threshold error is sampled.
REQ-024 err_pulse SHALL be high for exactly one cycle, the cycle after an erroneous bit is sampled; it SHALL never assert outside LOCKED.
REQ-025 err_cnt SHALL increment per error and saturate at 0xFFFF; bit_cnt SHALL increment per accepted bit in LOCKED and saturate at 0xFFFF_FFFF.
REQ-026 Both counters SHALL hold their value across loss of lock.
REQ-027 clr_cnt SHALL zero both counters next cycle and take priority over a simultaneous increment; err_pulse SHALL still assert for that error.
REQ-028 en = 0 SHALL force HUNT and clear fill_cnt, good_cnt, win_cnt and win_err; c and both counters SHALL hold.
REQ-029 Cycles without din_valid SHALL leave all state unchanged.

Reset
REQ-030 rst = 1 SHALL, on the next edge, set state = HUNT, c = 0, all internal counters = 0, locked = 0, err_pulse = 0, err_cnt = 0 and bit_cnt = 0.
REQ-031 rst SHALL take priority over en, din_valid and clr_cnt, including mid-lock and mid-window.

Verification
REQ-032 Clean stream from a generator model seeded 32'hACE1_2345, one bit per cycle -> locked = 1 after exactly 48 accepted bits; err_cnt = 0 and bit_cnt = 1000 after 1000 further bits.
REQ-033 Locked stream with the 100th post-lock bit inverted -> a single err_pulse one cycle later; err_cnt = 1 and locked stays 1.
REQ-034 8 inverted bits within one 64-bit window -> locked = 0 one cycle after the 8th error, err_cnt = 8; clean continuation -> relock after 48 bits with err_cnt still 8.
REQ-035 All-zero stream of 500 bits -> locked never asserts and state stays in HUNT; 7 errors per window over 10 windows -> lock is retained.
REQ-036 clr_cnt asserted in the same cycle as an error -> err_pulse = 1 and err_cnt = 0 next cycle.
REQ-037 rst pulsed while locked -> all outputs 0 next cycle, and the checker relocks after 48 further clean bits.
